// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use / branch-operand stall sequencing,
// IF/ID flush for taken branches and jumps, plus saturating stall/flush perf counters.
module hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_is_jump,
    input  logic             branch_taken,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             bubble_sel,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic RUN   = 1'b0;
    localparam logic STALL = 1'b1;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             match_ex, match_mem;
    logic [1:0]       need;

    always_comb begin
        match_ex  = (ex_rd != '0) && ((id_uses_rs && ex_rd == id_rs) ||
                                      (id_uses_rt && ex_rd == id_rt));
        match_mem = (mem_rd != '0) && ((id_uses_rs && mem_rd == id_rs) ||
                                       (id_uses_rt && mem_rd == id_rt));
        need = 2'd0;
        if (ex_mem_read && match_ex && id_is_branch)
            need = 2'd2;
        else if ((ex_mem_read && match_ex) ||
                 (id_is_branch && ex_reg_write && !ex_mem_read && match_ex) ||
                 (id_is_branch && mem_mem_read && match_mem))
            need = 2'd1;
    end

    // Reset forces the stall-shaped outputs so the front end holds while rst_n is low.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        bubble_sel = 1'b0;
        ifid_flush = 1'b0;
        if (!rst_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble_sel = 1'b1;
        end else if (state_q == STALL) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble_sel = 1'b1;
            if (rem_q == 2'd1) begin
                state_d = RUN;
                rem_d   = 2'd0;
            end else begin
                rem_d = rem_q - 2'd1;
            end
        end else if (need != 2'd0) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble_sel = 1'b1;
            if (need == 2'd2) begin
                state_d = STALL;
                rem_d   = 2'd1;
            end
        end else begin
            ifid_flush = (id_is_branch && branch_taken) || id_is_jump;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            rem_q   <= 2'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (bubble_sel && stall_q != '1) stall_q <= stall_q + ONE;
            if (ifid_flush && flush_q != '1) flush_q <= flush_q + ONE;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule
